// File: rtl/lut_logic_pkg.sv
// ---------------------------------------------------------------------------
// lut_logic_pkg
// Shared definitions for the LUT-based logic unit: the controller state
// encoding, the truth-table width helper and the largest supported fan-in.
// ---------------------------------------------------------------------------
package lut_logic_pkg;

  // Largest number of function inputs the unit is intended to support.
  localparam int MAX_N_IN = 6;

  // Controller states: IDLE accepts evaluations and configuration beats,
  // SWEEP walks every input combination and blocks everything else.
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  // Number of truth-table entries for an n-input function.
  function automatic int table_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// ---------------------------------------------------------------------------
// lut_cfg_loader
// Serial truth-table loader. Collects one table bit per accepted beat into a
// shadow register (index 0 first). The beat that fills the last index raises
// commit_o combinationally so the parent can capture the complete table on
// that same edge; cfg_done_o is the registered pulse of that commit.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   beat_i      one configuration bit accepted this cycle
//   bit_i       value of that configuration bit
//   table_o     shadow contents including the current beat's bit
//   commit_o    this beat completes the table (combinational)
//   cfg_done_o  one-cycle pulse after the commit edge
//   idle_o      no partial load in progress (count is zero)
// ---------------------------------------------------------------------------
module lut_cfg_loader
  import lut_logic_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      beat_i,
  input  logic                      bit_i,
  output logic [table_w(N_IN)-1:0]  table_o,
  output logic                      commit_o,
  output logic                      cfg_done_o,
  output logic                      idle_o
);

  localparam int TW = table_w(N_IN);

  logic [TW-1:0]   shadow_q, shadow_d;
  logic [N_IN-1:0] cnt_q, cnt_d;
  logic            done_q;

  // Next-state for the shadow register and beat counter. The counter is
  // exactly N_IN bits wide, so incrementing past the last index wraps to
  // zero on its own, which is the post-commit value we want.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    if (beat_i) begin
      shadow_d[cnt_q] = bit_i;
      cnt_d           = cnt_q + N_IN'(1);
      commit_o        = (cnt_q == N_IN'(TW - 1));
    end
  end

  // The parent needs the table including the bit arriving on the commit
  // beat, so expose the next-state value rather than the register.
  assign table_o    = shadow_d;
  assign cfg_done_o = done_q;
  assign idle_o     = (cnt_q == '0);

  // Loader registers; a reset mid-load discards the partial table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      done_q   <= commit_o;
    end
  end

endmodule

// File: rtl/lut_logic_unit.sv
// ---------------------------------------------------------------------------
// lut_logic_unit
// Registered N_IN-input boolean function held as a 2^N_IN-entry truth table.
// The table reloads serially through the cfg port, and a sweep engine can
// stream every (input, f) pair in ascending order while counting the ones.
//
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   in_valid, in_vec  evaluation request (accepted only when in_ready)
//   in_ready          high in IDLE
//   cfg_valid,cfg_bit serial table bit, index 0 first (accepted when cfg_ready)
//   cfg_ready         high in IDLE
//   cfg_done          one-cycle pulse when a new table commits
//   sweep_start       request an exhaustive sweep
//   sweep_busy        high while sweeping
//   sweep_done        pulse aligned with the last sweep output
//   sweep_ones        number of ones seen in the last completed sweep
//   out_valid,out_vec,f  registered result and the input that produced it
// ---------------------------------------------------------------------------
module lut_logic_unit
  import lut_logic_pkg::*;
#(
  parameter int                        N_IN          = 3,
  parameter logic [table_w(N_IN)-1:0]  DEFAULT_TABLE = 8'hE8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_ones,
  output logic            out_valid,
  output logic [N_IN-1:0] out_vec,
  output logic            f
);

  localparam int TW = table_w(N_IN);
  localparam int IW = N_IN + 1;

  state_e          state_q, state_d;
  logic [TW-1:0]   table_q, table_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   ones_q, ones_d;
  logic            out_valid_q, out_valid_d;
  logic [N_IN-1:0] out_vec_q, out_vec_d;
  logic            f_q, f_d;
  logic            done_q, done_d;

  logic [TW-1:0]   new_table;
  logic            commit;
  logic            cfg_idle;
  logic            sweep_bit;
  logic            sweep_last;

  assign in_ready   = (state_q == IDLE);
  assign cfg_ready  = (state_q == IDLE);
  assign sweep_busy = (state_q == SWEEP);

  lut_cfg_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_i     (cfg_valid && cfg_ready),
    .bit_i      (cfg_bit),
    .table_o    (new_table),
    .commit_o   (commit),
    .cfg_done_o (cfg_done),
    .idle_o     (cfg_idle)
  );

  // The index carries one spare bit so the terminal compare against the
  // last entry never aliases with a wrapped value.
  assign sweep_bit  = table_q[idx_q[N_IN-1:0]];
  assign sweep_last = (idx_q == IW'(TW - 1));

  // Next-state and output logic. Evaluations read table_q, so an evaluation
  // accepted on the commit beat still sees the old table.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    ones_d      = ones_q;
    out_valid_d = 1'b0;
    out_vec_d   = out_vec_q;
    f_d         = f_q;
    done_d      = 1'b0;
    table_d     = commit ? new_table : table_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          out_vec_d   = in_vec;
          f_d         = table_q[in_vec];
        end
        // A half-loaded table must not be swept.
        if (sweep_start && cfg_idle) begin
          state_d = SWEEP;
          idx_d   = '0;
          acc_d   = '0;
        end
      end

      SWEEP: begin
        out_valid_d = 1'b1;
        out_vec_d   = idx_q[N_IN-1:0];
        f_d         = sweep_bit;
        acc_d       = acc_q + IW'(sweep_bit);
        idx_d       = idx_q + IW'(1);
        if (sweep_last) begin
          done_d  = 1'b1;
          ones_d  = acc_q + IW'(sweep_bit);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, table and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      table_q     <= DEFAULT_TABLE;
      idx_q       <= '0;
      acc_q       <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      f_q         <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      f_q         <= f_d;
      done_q      <= done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_vec    = out_vec_q;
  assign f          = f_q;
  assign sweep_done = done_q;
  assign sweep_ones = ones_q;

endmodule

// File: tb/tb_lut_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_lut_logic_unit
// Scoreboard bench for lut_logic_unit with N_IN=3 and the majority default.
// A reference model tracks the table, loader count and sweep progress; every
// expected output is queued when stimulus is driven and compared when the
// unit presents out_valid.
// ---------------------------------------------------------------------------
module tb_lut_logic_unit;

  localparam int N_IN = 3;
  localparam int TW   = 8;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       in_valid    = 1'b0;
  logic [2:0] in_vec      = '0;
  logic       cfg_valid   = 1'b0;
  logic       cfg_bit     = 1'b0;
  logic       sweep_start = 1'b0;
  logic       in_ready;
  logic       cfg_ready;
  logic       cfg_done;
  logic       sweep_busy;
  logic       sweep_done;
  logic [3:0] sweep_ones;
  logic       out_valid;
  logic [2:0] out_vec;
  logic       f;

  typedef struct {
    logic [2:0] vec;
    logic       f;
    logic       done;
    int         due;
  } exp_t;

  exp_t       expQ[$];
  int         checks   = 0;
  int         errors   = 0;
  int         cycleCnt = 0;
  logic [7:0] modelTable;
  logic [7:0] modelShadow;
  int         modelCnt;
  int         sweepLeft;
  logic [3:0] modelOnes;

  always #5 clk = ~clk;

  lut_logic_unit #(
    .N_IN          (N_IN),
    .DEFAULT_TABLE (8'hE8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_vec      (in_vec),
    .in_ready    (in_ready),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_ready   (cfg_ready),
    .cfg_done    (cfg_done),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .sweep_ones  (sweep_ones),
    .out_valid   (out_valid),
    .out_vec     (out_vec),
    .f           (f)
  );

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d",
               tag, actual, expected, cycleCnt);
    end
  endtask

  // Output monitor: pops the scoreboard whenever a result is presented and
  // flags results that arrive unannounced or fail to arrive on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("out_vec", 64'(out_vec), 64'(e.vec));
          checkOutput("f", 64'(f), 64'(e.f));
          checkOutput("sweep_done", 64'(sweep_done), 64'(e.done));
          checkOutput("out_cycle", 64'(cycleCnt), 64'(e.due));
        end
      end else begin
        checkOutput("done_without_valid", 64'(sweep_done), 64'(0));
        if (expQ.size() != 0 && expQ[0].due <= cycleCnt) begin
          checkOutput("missing_out_valid", 64'(out_valid), 64'(1));
          expQ.delete(0);
        end
      end
    end
  end

  // Drives one cycle of stimulus, advances the model, then checks the
  // handshake/status outputs after the edge.
  task automatic applyStimulus(input logic iv, input logic [2:0] vec,
                               input logic cv, input logic cb,
                               input logic ss);
    logic       commit;
    logic [7:0] newTable;
    int         cntBefore;
    commit    = 1'b0;
    newTable  = modelTable;
    cntBefore = modelCnt;
    if (sweepLeft == 0) begin
      if (iv) expQ.push_back('{vec, modelTable[vec], 1'b0, cycleCnt + 1});
      if (cv) begin
        modelShadow[modelCnt] = cb;
        if (modelCnt == TW - 1) begin
          commit   = 1'b1;
          newTable = modelShadow;
        end
        modelCnt = (modelCnt + 1) % TW;
      end
      if (ss && cntBefore == 0) begin
        for (int k = 0; k < TW; k++)
          expQ.push_back('{3'(k), modelTable[k], (k == TW - 1), cycleCnt + 2 + k});
        sweepLeft = TW;
      end
    end else begin
      sweepLeft--;
      if (sweepLeft == 0) modelOnes = 4'($countones(modelTable));
    end
    in_valid    = iv;
    in_vec      = vec;
    cfg_valid   = cv;
    cfg_bit     = cb;
    sweep_start = ss;
    @(posedge clk);
    #1;
    if (commit) modelTable = newTable;
    checkOutput("in_ready", 64'(in_ready), 64'(sweepLeft == 0));
    checkOutput("cfg_ready", 64'(cfg_ready), 64'(sweepLeft == 0));
    checkOutput("sweep_busy", 64'(sweep_busy), 64'(sweepLeft != 0));
    checkOutput("cfg_done", 64'(cfg_done), 64'(commit));
    checkOutput("sweep_ones", 64'(sweep_ones), 64'(modelOnes));
  endtask

  // Asserts reset, checks the reset values and releases it.
  task automatic resetDut();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_vec      = '0;
    cfg_valid   = 1'b0;
    cfg_bit     = 1'b0;
    sweep_start = 1'b0;
    expQ.delete();
    modelTable  = 8'hE8;
    modelShadow = 8'h00;
    modelCnt    = 0;
    sweepLeft   = 0;
    modelOnes   = 4'd0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_vec", 64'(out_vec), 64'(0));
    checkOutput("rst_f", 64'(f), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    checkOutput("rst_cfg_done", 64'(cfg_done), 64'(0));
    checkOutput("rst_sweep_busy", 64'(sweep_busy), 64'(0));
    checkOutput("rst_sweep_done", 64'(sweep_done), 64'(0));
    checkOutput("rst_sweep_ones", 64'(sweep_ones), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic loadTable(input logic [7:0] pattern);
    for (int i = 0; i < TW; i++) applyStimulus(1'b0, 3'd0, 1'b1, pattern[i], 1'b0);
  endtask

  task automatic runSweep();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TW + 2; i++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] xorPattern;
    int         readyLow;
    xorPattern = 8'h96;

    resetDut();

    // Back-to-back evaluations against the majority table.
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Default-table sweep; count how long in_ready stays low.
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    readyLow = in_ready ? 0 : 1;
    for (int i = 0; i < TW + 2; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      if (!in_ready) readyLow++;
    end
    checkOutput("in_ready_low_cycles", 64'(readyLow), 64'(8));
    checkOutput("maj_sweep_ones", 64'(sweep_ones), 64'(4));

    // XOR3 load with an evaluation on the commit beat and the cycle after.
    for (int i = 0; i < TW - 1; i++)
      applyStimulus(1'b0, 3'd0, 1'b1, xorPattern[i], 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b1, xorPattern[7], 1'b0);
    checkOutput("commit_cycle_f", 64'(f), 64'(0));
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("post_commit_f", 64'(f), 64'(1));
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    runSweep();
    checkOutput("xor_sweep_ones", 64'(sweep_ones), 64'(4));

    // Sweep with cfg/in traffic hammering the ports: all of it is dropped.
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TW; i++) applyStimulus(1'b1, 3'(i), 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    runSweep();
    checkOutput("xor_kept_sweep_ones", 64'(sweep_ones), 64'(4));

    // Partial load blocks sweep_start until the table commits (AND3).
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("partial_sweep_blocked", 64'(sweep_busy), 64'(0));
    for (int i = 3; i < TW; i++) applyStimulus(1'b0, 3'd0, 1'b1, (i == 7), 1'b0);
    runSweep();
    checkOutput("and_sweep_ones", 64'(sweep_ones), 64'(1));

    // Reset at the fourth output of a sweep over an all-zero table.
    loadTable(8'h00);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    resetDut();
    runSweep();
    checkOutput("restored_sweep_ones", 64'(sweep_ones), 64'(4));

    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("queue_empty", 64'(expQ.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
